l1d_evict_data_collect: RTL and testbench

- Receive end of the MSHR evict read path: consumes per-offset data-array read beats produced by the evict request expansion logic.
- Assembles each line's beats, in any start offset with wrap-around, into a full cache line.
- Presents the assembled line plus tag/index as a single writeback request to the downstream (L2/bus) interface.
- Holds up to BUF_DEPTH assembled lines and drives downstream_evict_rdy back to the evict request path for flow control.

---
 rtl/l1d_evict_data_collect_pkg.sv | 53 +++++
 rtl/l1d_evict_data_collect_if.sv | 37 +++
 rtl/l1d_evict_line_buf.sv | 66 ++++++
 rtl/l1d_evict_data_collect.sv | 104 ++++++++++
 tb/tb_l1d_evict_data_collect.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/l1d_evict_data_collect_pkg.sv
// L1D evict-path shared widths and payload packing helpers.
// Imported by the evict data collector, its line buffer and its interface.
package l1d_package;

  localparam int L1D_OFFSET_WIDTH = 3;
  localparam int L1D_TAG_WIDTH    = 20;
  localparam int L1D_INDEX_WIDTH  = 6;
  localparam int L1D_DATA_WIDTH   = 64;
  localparam int L1D_LINE_WIDTH   = (1 << L1D_OFFSET_WIDTH) * L1D_DATA_WIDTH;

  typedef struct packed {
    logic [L1D_DATA_WIDTH-1:0]   data;
    logic [L1D_OFFSET_WIDTH-1:0] offset;
    logic                        last;
    logic [L1D_TAG_WIDTH-1:0]    tag;
    logic [L1D_INDEX_WIDTH-1:0]  index;
  } l1d_evict_rsp_pld_t;

  typedef struct packed {
    logic [L1D_TAG_WIDTH-1:0]   tag;
    logic [L1D_INDEX_WIDTH-1:0] index;
    logic [L1D_LINE_WIDTH-1:0]  data;
  } l1d_wb_req_pld_t;

  function automatic l1d_evict_rsp_pld_t pack_l1d_evict_rsp_pld(
    input logic [L1D_DATA_WIDTH-1:0]   data,
    input logic [L1D_OFFSET_WIDTH-1:0] offset,
    input logic                        last,
    input logic [L1D_TAG_WIDTH-1:0]    tag,
    input logic [L1D_INDEX_WIDTH-1:0]  index
  );
    l1d_evict_rsp_pld_t p;
    p.data   = data;
    p.offset = offset;
    p.last   = last;
    p.tag    = tag;
    p.index  = index;
    return p;
  endfunction

  function automatic l1d_wb_req_pld_t pack_l1d_wb_req_pld(
    input logic [L1D_TAG_WIDTH-1:0]   tag,
    input logic [L1D_INDEX_WIDTH-1:0] index,
    input logic [L1D_LINE_WIDTH-1:0]  data
  );
    l1d_wb_req_pld_t p;
    p.tag   = tag;
    p.index = index;
    p.data  = data;
    return p;
  endfunction

endpackage

// File: rtl/l1d_evict_data_collect_if.sv
// Evict read-beat input and writeback-request output bundle of the collector.
interface l1d_evict_data_collect_if import l1d_package::*; #(
  parameter int DATA_WIDTH   = L1D_DATA_WIDTH,
  parameter int OFFSET_WIDTH = L1D_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = L1D_TAG_WIDTH,
  parameter int INDEX_WIDTH  = L1D_INDEX_WIDTH
);
  localparam int BEATS = 1 << OFFSET_WIDTH;

  logic                          evict_rsp_vld;
  logic [DATA_WIDTH-1:0]         evict_rsp_data;
  logic [OFFSET_WIDTH-1:0]       evict_rsp_offset;
  logic                          evict_rsp_last;
  logic [TAG_WIDTH-1:0]          evict_rsp_tag;
  logic [INDEX_WIDTH-1:0]        evict_rsp_index;
  logic                          downstream_evict_rdy;
  logic                          wb_req_vld;
  logic                          wb_req_rdy;
  logic [TAG_WIDTH-1:0]          wb_req_tag;
  logic [INDEX_WIDTH-1:0]        wb_req_index;
  logic [BEATS*DATA_WIDTH-1:0]   wb_req_data;
  logic                          proto_err;

  modport master (
    output evict_rsp_vld, evict_rsp_data, evict_rsp_offset, evict_rsp_last,
           evict_rsp_tag, evict_rsp_index, wb_req_rdy,
    input  downstream_evict_rdy, wb_req_vld, wb_req_tag, wb_req_index,
           wb_req_data, proto_err
  );

  modport slave (
    input  evict_rsp_vld, evict_rsp_data, evict_rsp_offset, evict_rsp_last,
           evict_rsp_tag, evict_rsp_index, wb_req_rdy,
    output downstream_evict_rdy, wb_req_vld, wb_req_tag, wb_req_index,
           wb_req_data, proto_err
  );
endinterface

// File: rtl/l1d_evict_line_buf.sv
// DEPTH-entry line store: per-beat writes into the entry at wr_ptr, whole-line read at rd_ptr.
// Data and headers are not reset; only the pointers are.
module l1d_evict_line_buf #(
  parameter int DEPTH        = 2,
  parameter int OFFSET_WIDTH = 3,
  parameter int DATA_WIDTH   = 64,
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 6
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en_i,
  input  logic [OFFSET_WIDTH-1:0]                wr_off_i,
  input  logic [DATA_WIDTH-1:0]                  wr_data_i,
  input  logic                                   hdr_we_i,
  input  logic [TAG_WIDTH-1:0]                   hdr_tag_i,
  input  logic [INDEX_WIDTH-1:0]                 hdr_index_i,
  input  logic                                   wr_adv_i,
  input  logic                                   rd_adv_i,
  output logic [TAG_WIDTH-1:0]                   rd_tag_o,
  output logic [INDEX_WIDTH-1:0]                 rd_index_o,
  output logic [(1<<OFFSET_WIDTH)*DATA_WIDTH-1:0] rd_data_o
);
  localparam int BEATS = 1 << OFFSET_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_WIDTH-1:0]  data_q  [DEPTH][BEATS];
  logic [TAG_WIDTH-1:0]   tag_q   [DEPTH];
  logic [INDEX_WIDTH-1:0] index_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;

  // Power-of-two depth wraps naturally; a single entry pins the pointer at 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_adv_i) wr_ptr_d = (DEPTH == 1) ? '0 : wr_ptr_q + PTR_ONE;
    if (rd_adv_i) rd_ptr_d = (DEPTH == 1) ? '0 : rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) data_q[wr_ptr_q][wr_off_i] <= wr_data_i;
    if (hdr_we_i) begin
      tag_q[wr_ptr_q]   <= hdr_tag_i;
      index_q[wr_ptr_q] <= hdr_index_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_ptr_q];
  assign rd_index_o = index_q[rd_ptr_q];

  for (genvar k = 0; k < BEATS; k++) begin : g_rd
    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_ptr_q][k];
  end
endmodule

// File: rtl/l1d_evict_data_collect.sv
// Collects offset-addressed evict read beats into whole lines and queues them as writeback requests.
// Line appears on wb_req one cycle after its last beat; beats are refused only between lines when the queue is full.
module l1d_evict_data_collect import l1d_package::*; #(
  parameter int DATA_WIDTH   = L1D_DATA_WIDTH,
  parameter int OFFSET_WIDTH = L1D_OFFSET_WIDTH,
  parameter int TAG_WIDTH    = L1D_TAG_WIDTH,
  parameter int INDEX_WIDTH  = L1D_INDEX_WIDTH,
  parameter int BUF_DEPTH    = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  l1d_evict_data_collect_if.slave io
);
  localparam int BEATS = 1 << OFFSET_WIDTH;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [OFFSET_WIDTH:0] BCNT_ONE = (OFFSET_WIDTH+1)'(1);
  localparam logic [OFFSET_WIDTH:0] BCNT_ALL = (OFFSET_WIDTH+1)'(BEATS);

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [OFFSET_WIDTH:0]   beat_cnt_q, beat_cnt_d;
  logic                    proto_err_q, proto_err_d;
  logic                    rdy, beat_acc, line_done, wb_hs;
  l1d_evict_rsp_pld_t      rsp;
  l1d_wb_req_pld_t         wb;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic [INDEX_WIDTH-1:0]  rd_index;
  logic [BEATS*DATA_WIDTH-1:0] rd_data;

  assign rsp = pack_l1d_evict_rsp_pld(io.evict_rsp_data, io.evict_rsp_offset,
                                      io.evict_rsp_last, io.evict_rsp_tag, io.evict_rsp_index);

  // Mid-line beats are always accepted: a line is only started when a slot is free.
  assign rdy       = (state_q == ST_FILL) || (count_q < CNT_FULL);
  assign beat_acc  = io.evict_rsp_vld && rdy;
  assign line_done = beat_acc && rsp.last;
  assign wb_hs     = (count_q != '0) && io.wb_req_rdy;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = io.evict_rsp_vld && !rdy;
    if (beat_acc) begin
      if (rsp.last) begin
        proto_err_d = (beat_cnt_q + BCNT_ONE) != BCNT_ALL;
        beat_cnt_d  = '0;
        state_d     = ST_IDLE;
      end else begin
        beat_cnt_d  = beat_cnt_q + BCNT_ONE;
        state_d     = ST_FILL;
      end
    end
    count_d = count_q + (line_done ? CNT_ONE : '0) - (wb_hs ? CNT_ONE : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  l1d_evict_line_buf #(
    .DEPTH        (BUF_DEPTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .TAG_WIDTH    (TAG_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (beat_acc),
    .wr_off_i    (rsp.offset),
    .wr_data_i   (rsp.data),
    .hdr_we_i    (beat_acc && (state_q == ST_IDLE)),
    .hdr_tag_i   (rsp.tag),
    .hdr_index_i (rsp.index),
    .wr_adv_i    (line_done),
    .rd_adv_i    (wb_hs),
    .rd_tag_o    (rd_tag),
    .rd_index_o  (rd_index),
    .rd_data_o   (rd_data)
  );

  assign wb = pack_l1d_wb_req_pld(rd_tag, rd_index, rd_data);

  assign io.downstream_evict_rdy = rdy;
  assign io.wb_req_vld           = (count_q != '0);
  assign io.wb_req_tag           = wb.tag;
  assign io.wb_req_index         = wb.index;
  assign io.wb_req_data          = wb.data;
  assign io.proto_err            = proto_err_q;
endmodule

// File: tb/tb_l1d_evict_data_collect.sv
// Directed bench for the evict data collector: vector table for whole lines plus hand sequences for queue corners.
module tb_l1d_evict_data_collect;
  import l1d_package::*;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  l1d_evict_data_collect_if io();

  l1d_evict_data_collect dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  off;
    logic [63:0] data;
    logic        last;
    logic [19:0] tag;
    logic [5:0]  idx;
    logic        wb_rdy;
    logic        exp_ds;
    logic        exp_vld;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one cycle of inputs, lets one posedge pass, then drops the beat valid.
  task automatic cyc(input logic v, input logic [2:0] off, input logic [63:0] d,
                     input logic lst, input logic [19:0] tg, input logic [5:0] ix,
                     input logic wr);
    io.evict_rsp_vld    = v;
    io.evict_rsp_offset = off;
    io.evict_rsp_data   = d;
    io.evict_rsp_last   = lst;
    io.evict_rsp_tag    = tg;
    io.evict_rsp_index  = ix;
    io.wb_req_rdy       = wr;
    @(negedge clk);
    io.evict_rsp_vld    = 1'b0;
    io.evict_rsp_last   = 1'b0;
  endtask

  task automatic idle(input logic wr);
    cyc(1'b0, 3'd0, 64'd0, 1'b0, 20'd0, 6'd0, wr);
  endtask

  task automatic send_beats(input logic [19:0] tg, input logic [5:0] ix, input logic [63:0] base,
                            input int n, input logic lst, input logic wr);
    for (int k = 0; k < n; k++)
      cyc(1'b1, 3'(k), base + 64'(k), lst && (k == n - 1), (k == 0) ? tg : ~tg,
          (k == 0) ? ix : ~ix, wr);
  endtask

  task automatic chk_data(input string nm, input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_beat%0d", nm, k), io.wb_req_data[k*64 +: 64], base + 64'(k));
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      cyc(tbl[i].vld, tbl[i].off, tbl[i].data, tbl[i].last, tbl[i].tag, tbl[i].idx, tbl[i].wb_rdy);
      chk($sformatf("tbl%0d_ds_rdy", i), 64'(io.downstream_evict_rdy), 64'(tbl[i].exp_ds));
      chk($sformatf("tbl%0d_wb_vld", i), 64'(io.wb_req_vld), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_err", i), 64'(io.proto_err), 64'(tbl[i].exp_err));
    end
  endtask

  initial begin
    logic [2:0] wrap_off;
    rst_n = 1'b0;
    io.evict_rsp_vld = 1'b0; io.evict_rsp_data = '0; io.evict_rsp_offset = '0;
    io.evict_rsp_last = 1'b0; io.evict_rsp_tag = '0; io.evict_rsp_index = '0;
    io.wb_req_rdy = 1'b0;

    // In-order line, first-beat header 0xABCDE/0x15, downstream always ready.
    for (int k = 0; k < 8; k++)
      tbl.push_back('{1'b1, 3'(k), 64'h1000 + 64'(k), k == 7, (k == 0) ? 20'hABCDE : 20'h11111,
                      (k == 0) ? 6'h15 : 6'h2A, 1'b1, 1'b1, k == 7, 1'b0});
    // Critical-word-first line starting at offset 5, downstream stalled.
    for (int j = 0; j < 8; j++) begin
      wrap_off = 3'(j + 5);
      tbl.push_back('{1'b1, wrap_off, 64'h2000 + 64'(wrap_off), j == 7,
                      (j == 0) ? 20'h5A5A5 : 20'h0F0F0, (j == 0) ? 6'h07 : 6'h38,
                      1'b0, 1'b1, j == 7, 1'b0});
    end

    #1;
    chk("rst_wb_vld", 64'(io.wb_req_vld), 64'd0);
    chk("rst_err", 64'(io.proto_err), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ds_rdy", 64'(io.downstream_evict_rdy), 64'd1);

    run_tbl(0, 8);
    chk("t1_tag", 64'(io.wb_req_tag), 64'hABCDE);
    chk("t1_idx", 64'(io.wb_req_index), 64'h15);
    chk_data("t1", 64'h1000, 8);
    idle(1'b1);
    chk("t1_pop_vld", 64'(io.wb_req_vld), 64'd0);

    run_tbl(8, 16);
    chk("t2_tag", 64'(io.wb_req_tag), 64'h5A5A5);
    chk_data("t2", 64'h2000, 8);
    idle(1'b1);
    chk("t2_pop_vld", 64'(io.wb_req_vld), 64'd0);

    // Queue fills with two lines; a beat offered while full is dropped.
    send_beats(20'h00031, 6'd1, 64'h3100, 8, 1'b1, 1'b0);
    chk("t3_l1_ds_rdy", 64'(io.downstream_evict_rdy), 64'd1);
    send_beats(20'h00032, 6'd2, 64'h3200, 8, 1'b1, 1'b0);
    chk("t3_full_ds_rdy", 64'(io.downstream_evict_rdy), 64'd0);
    cyc(1'b1, 3'd0, 64'hDEAD, 1'b1, 20'hFFFFF, 6'h3F, 1'b0);
    chk("t3_drop_err", 64'(io.proto_err), 64'd1);
    chk("t3_drop_ds_rdy", 64'(io.downstream_evict_rdy), 64'd0);
    chk("t3_head_tag", 64'(io.wb_req_tag), 64'h00031);
    chk_data("t3_l1", 64'h3100, 8);
    idle(1'b1);
    chk("t3_hs_ds_rdy", 64'(io.downstream_evict_rdy), 64'd1);
    chk("t3_hs_err", 64'(io.proto_err), 64'd0);
    chk("t3_l2_tag", 64'(io.wb_req_tag), 64'h00032);
    chk_data("t3_l2", 64'h3200, 8);
    send_beats(20'h00033, 6'd3, 64'h3300, 8, 1'b1, 1'b0);
    chk("t3_refull_ds_rdy", 64'(io.downstream_evict_rdy), 64'd0);
    idle(1'b1);
    chk("t3_l3_tag", 64'(io.wb_req_tag), 64'h00033);
    chk_data("t3_l3", 64'h3300, 8);
    idle(1'b1);
    chk("t3_drain_vld", 64'(io.wb_req_vld), 64'd0);

    // Line B completes in the same cycle line A is handed off.
    send_beats(20'h00041, 6'd4, 64'h4100, 8, 1'b1, 1'b0);
    chk("t4_a_vld", 64'(io.wb_req_vld), 64'd1);
    send_beats(20'h00042, 6'd5, 64'h4200, 7, 1'b0, 1'b0);
    cyc(1'b1, 3'd7, 64'h4207, 1'b1, 20'h0, 6'h0, 1'b1);
    chk("t4_vld", 64'(io.wb_req_vld), 64'd1);
    chk("t4_b_tag", 64'(io.wb_req_tag), 64'h00042);
    chk("t4_b_idx", 64'(io.wb_req_index), 64'h05);
    chk_data("t4_b", 64'h4200, 8);
    idle(1'b1);
    chk("t4_pop_vld", 64'(io.wb_req_vld), 64'd0);

    // Short line: error pulse for one cycle, line still emitted.
    send_beats(20'h00051, 6'd6, 64'h5100, 5, 1'b1, 1'b0);
    chk("t5_err", 64'(io.proto_err), 64'd1);
    chk("t5_vld", 64'(io.wb_req_vld), 64'd1);
    idle(1'b0);
    chk("t5_err_clr", 64'(io.proto_err), 64'd0);
    chk("t5_tag", 64'(io.wb_req_tag), 64'h00051);
    chk_data("t5", 64'h5100, 5);
    idle(1'b1);
    chk("t5_pop_vld", 64'(io.wb_req_vld), 64'd0);

    // Reset with one queued line and a partial fill in progress.
    send_beats(20'h00061, 6'd7, 64'h6100, 8, 1'b1, 1'b0);
    send_beats(20'h00062, 6'd8, 64'h6200, 3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(io.wb_req_vld), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_ds_rdy", 64'(io.downstream_evict_rdy), 64'd1);
    chk("t6_vld", 64'(io.wb_req_vld), 64'd0);
    send_beats(20'h00063, 6'd9, 64'h6300, 8, 1'b1, 1'b1);
    chk("t6_err", 64'(io.proto_err), 64'd0);
    chk("t6_new_vld", 64'(io.wb_req_vld), 64'd1);
    chk("t6_tag", 64'(io.wb_req_tag), 64'h00063);
    chk_data("t6", 64'h6300, 8);
    idle(1'b1);
    chk("t6_pop_vld", 64'(io.wb_req_vld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
